timer_bank: RTL and testbench

- Parametrised successor to the single down-counter.
- Provides CN independent down-counting timer channels, each CW bits wide, driven by one shared programmable prescaler.
- Each channel supports one-shot or periodic (auto-reload) mode, synchronous load and stop, a running status and a one-cycle expiry pulse.
- Sits beside the 1-wire master as its bit-slot and reset/presence timing source; software or the master FSM loads channels and reacts to expiry.

---
 rtl/timer_bank_pkg.sv | 7 +
 rtl/timer_chan.sv | 64 ++++++
 rtl/timer_bank.sv | 53 +++++
 tb/tb_timer_bank.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_bank_pkg.sv
// Shared constants for the timer bank: channel mode encodings.
package timer_bank_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: down-counter with reload register, mode and registered expiry pulse.
module timer_chan
  import timer_bank_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          mode,
  input  logic          stp,
  output logic [CW-1:0] cnt,
  output logic          run,
  output logic          exp
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rl_q, rl_d;
  logic          md_q, md_d;
  logic          exp_q, exp_d;

  // Priority: stop, then load, then tick-driven decrement; zero never decrements.
  always_comb begin
    cnt_d = cnt_q;
    rl_d  = rl_q;
    md_d  = md_q;
    exp_d = 1'b0;
    if (stp) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
      rl_d  = ld_val;
      md_d  = mode;
    end else if (tick && (cnt_q != '0)) begin
      if (cnt_q == CW'(1)) begin
        exp_d = 1'b1;
        cnt_d = (md_q == MODE_PERIODIC) ? rl_q : '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      rl_q  <= '0;
      md_q  <= MODE_ONESHOT;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rl_q  <= rl_d;
      md_q  <= md_d;
      exp_q <= exp_d;
    end
  end

  assign cnt = cnt_q;
  assign run = (cnt_q != '0);
  assign exp = exp_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of CN down-counting timer channels sharing one programmable prescaler.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned CW = 8,
  parameter int unsigned CN = 4,
  parameter int unsigned PW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PW-1:0]    pre_div,
  input  logic [CN-1:0]    ld,
  input  logic [CN*CW-1:0] ld_val,
  input  logic [CN-1:0]    mode,
  input  logic [CN-1:0]    stp,
  output logic             tick,
  output logic [CN*CW-1:0] cnt,
  output logic [CN-1:0]    run,
  output logic [CN-1:0]    exp
);

  logic [PW-1:0] pcnt_q, pcnt_d;

  // >= rather than == so lowering pre_div below pcnt ticks at once instead of wrapping.
  assign tick   = (pcnt_q >= pre_div);
  assign pcnt_d = tick ? '0 : pcnt_q + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  for (genvar i = 0; i < CN; i++) begin : g_chan
    timer_chan #(
      .CW(CW)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .ld    (ld[i]),
      .ld_val(ld_val[i*CW +: CW]),
      .mode  (mode[i]),
      .stp   (stp[i]),
      .cnt   (cnt[i*CW +: CW]),
      .run   (run[i]),
      .exp   (exp[i])
    );
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: vector table, directed corners and random vs. a model.
module tb_timer_bank;

  localparam int CW = 8;
  localparam int CN = 4;
  localparam int PW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [PW-1:0]    pre_div;
  logic [CN-1:0]    ld, mode, stp;
  logic [CN*CW-1:0] ld_val;
  logic             tick;
  logic [CN*CW-1:0] cnt;
  logic [CN-1:0]    run, exp;

  timer_bank #(
    .CW(CW),
    .CN(CN),
    .PW(PW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pre_div(pre_div),
    .ld     (ld),
    .ld_val (ld_val),
    .mode   (mode),
    .stp    (stp),
    .tick   (tick),
    .cnt    (cnt),
    .run    (run),
    .exp    (exp)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: plain integers per channel.
  int m_pcnt;
  int m_cnt[CN];
  int m_rl[CN];
  bit m_md[CN];
  bit m_exp[CN];

  typedef struct {
    logic       ld;
    logic [7:0] val;
    logic       md;
    logic       sp;
    logic [7:0] ecnt;
    logic       erun;
    logic       eexp;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int m_tick();
    return (m_pcnt >= int'(pre_div)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_pcnt = 0;
    for (int i = 0; i < CN; i++) begin
      m_cnt[i] = 0;
      m_rl[i]  = 0;
      m_md[i]  = 1'b0;
      m_exp[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int t;
    t = m_tick();
    for (int i = 0; i < CN; i++) begin
      int v;
      v = int'(ld_val[i*CW +: CW]);
      m_exp[i] = 1'b0;
      if (stp[i]) begin
        m_cnt[i] = 0;
      end else if (ld[i]) begin
        m_cnt[i] = v;
        m_rl[i]  = v;
        m_md[i]  = mode[i];
      end else if (t == 1 && m_cnt[i] == 1) begin
        m_exp[i] = 1'b1;
        m_cnt[i] = m_md[i] ? m_rl[i] : 0;
      end else if (t == 1 && m_cnt[i] > 1) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
    m_pcnt = (t == 1) ? 0 : m_pcnt + 1;
  endtask

  task automatic compare();
    logic [CN*CW-1:0] ec;
    logic [CN-1:0]    er, ee;
    for (int i = 0; i < CN; i++) begin
      ec[i*CW +: CW] = CW'(m_cnt[i]);
      er[i]          = (m_cnt[i] != 0);
      ee[i]          = m_exp[i];
    end
    chk("model_tick", 64'(tick), 64'(m_tick()));
    chk("model_cnt", 64'(cnt), 64'(ec));
    chk("model_run", 64'(run), 64'(er));
    chk("model_exp", 64'(exp), 64'(ee));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    else model_reset();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    ld     = '0;
    stp    = '0;
    mode   = '0;
    ld_val = '0;
  endtask

  function automatic vec_t mk(int l, int v, int m, int s, int ec, int er, int ee);
    vec_t r;
    r.ld   = 1'(l);
    r.val  = 8'(v);
    r.md   = 1'(m);
    r.sp   = 1'(s);
    r.ecnt = 8'(ec);
    r.erun = 1'(er);
    r.eexp = 1'(ee);
    return r;
  endfunction

  initial begin
    int pulses[$];
    int found;

    // Channel 0 sequence with pre_div=0: {ld, val, mode, stp} -> {cnt0, run0, exp0}.
    tbl[0]  = mk(1, 5, 0, 0, 5, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 4, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 3, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 2, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 1, 0, 1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 1, 1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 1, 1, 1);
    tbl[10] = mk(1, 7, 0, 1, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 2, 0, 0, 2, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 1, 1, 0);
    tbl[15] = mk(1, 7, 0, 0, 7, 1, 0);
    tbl[16] = mk(0, 0, 0, 1, 0, 0, 0);

    pre_div = '0;
    idle_inputs();
    rst = 1'b0;
    model_reset();

    // Reset held for 3 clocks, then idle.
    repeat (3) step();
    chk("rst_tick", 64'(tick), 64'(1));
    chk("rst_cnt", 64'(cnt), 64'(0));
    rst = 1'b1;
    repeat (2) step();
    chk("idle_run", 64'(run), 64'(0));
    chk("idle_tick", 64'(tick), 64'(1));

    // Vector table on channel 0.
    foreach (tbl[r]) begin
      ld[0]         = tbl[r].ld;
      ld_val[7:0]   = tbl[r].val;
      mode[0]       = tbl[r].md;
      stp[0]        = tbl[r].sp;
      step();
      chk($sformatf("tbl%0d_cnt0", r), 64'(cnt[7:0]), 64'(tbl[r].ecnt));
      chk($sformatf("tbl%0d_run0", r), 64'(run[0]), 64'(tbl[r].erun));
      chk($sformatf("tbl%0d_exp0", r), 64'(exp[0]), 64'(tbl[r].eexp));
      idle_inputs();
    end

    // Periodic on channel 1 with pre_div=2: expiries 9 clocks apart, run never drops.
    pre_div      = 4'd2;
    ld[1]        = 1'b1;
    ld_val[15:8] = 8'd3;
    mode[1]      = 1'b1;
    step();
    idle_inputs();
    for (int c = 1; c <= 40; c++) begin
      step();
      chk("per_run1", 64'(run[1]), 64'(1));
      if (exp[1]) pulses.push_back(c);
    end
    chk("per_npulses_ge4", 64'(pulses.size() >= 4), 64'(1));
    for (int k = 1; k < pulses.size(); k++) begin
      chk("per_spacing", 64'(pulses[k] - pulses[k-1]), 64'(9));
    end
    stp[1] = 1'b1;
    step();
    idle_inputs();

    // Priority on channel 2 at the expiry edge.
    pre_div       = '0;
    ld[2]         = 1'b1;
    ld_val[23:16] = 8'd3;
    step();
    idle_inputs();
    repeat (2) step();
    chk("pri_cnt2_is1", 64'(cnt[23:16]), 64'(1));
    stp[2]        = 1'b1;
    ld[2]         = 1'b1;
    ld_val[23:16] = 8'd7;
    step();
    chk("pri_stp_cnt2", 64'(cnt[23:16]), 64'(0));
    chk("pri_stp_exp2", 64'(exp[2]), 64'(0));
    stp[2] = 1'b0;
    ld_val[23:16] = 8'd1;
    step();
    ld_val[23:16] = 8'd7;
    step();
    chk("pri_ld_cnt2", 64'(cnt[23:16]), 64'(7));
    chk("pri_ld_exp2", 64'(exp[2]), 64'(0));
    idle_inputs();
    stp[2] = 1'b1;
    step();
    idle_inputs();

    // Full-range load on channel 3: expiry exactly 255 clocks after load is visible.
    ld[3]         = 1'b1;
    ld_val[31:24] = 8'hff;
    step();
    idle_inputs();
    chk("max_cnt3", 64'(cnt[31:24]), 64'(255));
    found = 0;
    for (int c = 1; c <= 300 && found == 0; c++) begin
      step();
      if (exp[3]) begin
        found = 1;
        chk("max_latency", 64'(c), 64'(255));
      end
    end
    chk("max_found", 64'(found), 64'(1));

    // Lower pre_div from 15 to 1 while pcnt is 10.
    pre_div = 4'd15;
    for (int c = 0; c < 40 && m_pcnt != 10; c++) step();
    chk("lower_reach_pcnt10", 64'(m_pcnt), 64'(10));
    chk("lower_no_tick_before", 64'(tick), 64'(0));
    pre_div = 4'd1;
    #1;
    chk("lower_tick_now", 64'(tick), 64'(1));
    step();
    chk("lower_tick_a", 64'(tick), 64'(0));
    step();
    chk("lower_tick_b", 64'(tick), 64'(1));
    step();
    chk("lower_tick_c", 64'(tick), 64'(0));

    // Asynchronous reset mid-count on all channels.
    pre_div = '0;
    ld      = '1;
    mode    = '1;
    ld_val  = {4{8'd20}};
    step();
    idle_inputs();
    repeat (3) step();
    #3;
    rst = 1'b0;
    #1;
    chk("arst_cnt", 64'(cnt), 64'(0));
    chk("arst_run", 64'(run), 64'(0));
    chk("arst_exp", 64'(exp), 64'(0));
    model_reset();
    repeat (2) step();
    rst = 1'b1;
    for (int c = 0; c < 25; c++) begin
      step();
      chk("arst_no_exp", 64'(exp), 64'(0));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 31) == 0) pre_div = PW'($urandom_range(0, 3));
      for (int i = 0; i < CN; i++) begin
        ld[i]   = ($urandom_range(0, 7) == 0);
        stp[i]  = ($urandom_range(0, 15) == 0);
        mode[i] = 1'($urandom_range(0, 1));
        ld_val[i*CW +: CW] = ($urandom_range(0, 15) == 0) ? 8'hff : CW'($urandom_range(0, 6));
      end
      step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
